// File: rtl/pong_game_ctrl.sv
// Pong game controller: start/play/new-ball/game-over sequencing with BCD scores.
// Optional build macro PONG_CTRL_AUTOSTART_EN: NEWGAME also starts play after HOLD_TICKS refresh ticks.
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE  = 5,
  parameter int unsigned HOLD_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       pts_1,
  input  logic       pts_2,
  input  logic       btn_start,
  output logic       gra_still,
  output logic [7:0] score_1,
  output logic [7:0] score_2,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {NEWGAME, PLAY, NEWBALL, OVER} state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLD_TICKS);
  localparam logic [6:0] WIN_BIN   = 7'(WIN_SCORE);

  state_t     state_q;
  logic       pts1_q, pts2_q, btn_q;
  logic       still_q, over_q;
  logic [1:0] winner_q;
  logic [7:0] score1_q, score2_q, hold_q;
  logic [6:0] bin1_q, bin2_q;

  logic       pts1_rise, pts2_rise, btn_rise, start_go;
  logic [7:0] score1_d, score2_d;
  logic [6:0] bin1_d, bin2_d;

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99) return s;
    if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bin_inc(input logic [6:0] b);
    return (b == 7'd99) ? b : b + 7'd1;
  endfunction

  assign pts1_rise = pts_1 & ~pts1_q;
  assign pts2_rise = pts_2 & ~pts2_q;
  assign btn_rise  = btn_start & ~btn_q;
  assign score1_d  = bcd_inc(score1_q);
  assign score2_d  = bcd_inc(score2_q);
  assign bin1_d    = bin_inc(bin1_q);
  assign bin2_d    = bin_inc(bin2_q);

  always_comb begin
    start_go = 1'b0;
    if (state_q == NEWGAME) begin
`ifdef PONG_CTRL_AUTOSTART_EN
      start_go = btn_rise | (refresh_tick & (hold_q == 8'd1));
`else
      start_go = btn_rise;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= NEWGAME;
      pts1_q   <= 1'b0;
      pts2_q   <= 1'b0;
      btn_q    <= 1'b0;
      still_q  <= 1'b1;
      over_q   <= 1'b0;
      winner_q <= 2'b00;
      score1_q <= 8'h00;
      score2_q <= 8'h00;
      bin1_q   <= 7'd0;
      bin2_q   <= 7'd0;
      hold_q   <= 8'd0;
    end else begin
      pts1_q <= pts_1;
      pts2_q <= pts_2;
      btn_q  <= btn_start;
      case (state_q)
        NEWGAME: begin
          if (start_go) begin
            state_q  <= PLAY;
            still_q  <= 1'b0;
            winner_q <= 2'b00;
            score1_q <= 8'h00;
            score2_q <= 8'h00;
            bin1_q   <= 7'd0;
            bin2_q   <= 7'd0;
          end
`ifdef PONG_CTRL_AUTOSTART_EN
          // A zero counter here means we arrived from reset and have not loaded yet.
          else if (hold_q == 8'd0) hold_q <= HOLD_INIT;
          else if (refresh_tick) hold_q <= hold_q - 8'd1;
`endif
        end
        PLAY: begin
          if (pts1_rise) begin
            score1_q <= score1_d;
            bin1_q   <= bin1_d;
            still_q  <= 1'b1;
            hold_q   <= HOLD_INIT;
            if (bin1_d == WIN_BIN) begin
              state_q  <= OVER;
              over_q   <= 1'b1;
              winner_q <= 2'b01;
            end else state_q <= NEWBALL;
          end else if (pts2_rise) begin
            score2_q <= score2_d;
            bin2_q   <= bin2_d;
            still_q  <= 1'b1;
            hold_q   <= HOLD_INIT;
            if (bin2_d == WIN_BIN) begin
              state_q  <= OVER;
              over_q   <= 1'b1;
              winner_q <= 2'b10;
            end else state_q <= NEWBALL;
          end
        end
        NEWBALL: begin
          if (refresh_tick) begin
            if (hold_q == 8'd1) begin
              state_q <= PLAY;
              still_q <= 1'b0;
            end else hold_q <= hold_q - 8'd1;
          end
        end
        OVER: begin
          if (refresh_tick) begin
            if (hold_q == 8'd1) begin
              state_q <= NEWGAME;
              over_q  <= 1'b0;
              hold_q  <= HOLD_INIT;
            end else hold_q <= hold_q - 8'd1;
          end
        end
        default: state_q <= NEWGAME;
      endcase
    end
  end

  assign gra_still = still_q;
  assign score_1   = score1_q;
  assign score_2   = score2_q;
  assign game_over = over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with WIN_SCORE=12, HOLD_TICKS=120.
module tb_pong_game_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refresh_tick = 1'b0;
  logic       pts_1 = 1'b0;
  logic       pts_2 = 1'b0;
  logic       btn_start = 1'b0;
  logic       gra_still;
  logic [7:0] score_1, score_2;
  logic       game_over;
  logic [1:0] winner;

  int n_checks = 0;
  int n_fail   = 0;

  pong_game_ctrl #(.WIN_SCORE(12), .HOLD_TICKS(120)) dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick),
    .pts_1(pts_1), .pts_2(pts_2), .btn_start(btn_start),
    .gra_still(gra_still), .score_1(score_1), .score_2(score_2),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      refresh_tick = 1'b1;
      step();
      refresh_tick = 1'b0;
      step();
    end
  endtask

  logic [7:0] exp_bcd;
  int         falls;
  logic       prev_still;
  logic       exp_auto;

  initial begin
    step();
    step();
    check("rst_still", gra_still, 1);
    check("rst_s1", score_1, 8'h00);
    check("rst_s2", score_2, 8'h00);
    check("rst_over", game_over, 0);
    check("rst_win", winner, 2'b00);
    reset = 1'b0;
    step();

    // Start button held for 10 cycles must start exactly one game.
    btn_start = 1'b1;
    falls = 0;
    prev_still = gra_still;
    for (int i = 0; i < 10; i++) begin
      step();
      if (prev_still && !gra_still) falls++;
      prev_still = gra_still;
    end
    btn_start = 1'b0;
    step();
    check("start_falls", falls, 1);
    check("start_still", gra_still, 0);
    check("start_s1", score_1, 8'h00);
    check("start_s2", score_2, 8'h00);

    // Long pts_1 level scores once.
    pts_1 = 1'b1;
    for (int i = 0; i < 50; i++) step();
    pts_1 = 1'b0;
    step();
    check("p1_once", score_1, 8'h01);
    check("p1_newball", gra_still, 1);
    ticks(119);
    check("p1_hold119", gra_still, 1);
    ticks(1);
    check("p1_play", gra_still, 0);

    // Button ignored in PLAY.
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
    check("btn_play_s1", score_1, 8'h01);
    check("btn_play_still", gra_still, 0);

    // Simultaneous edges: player 1 wins the tie.
    pts_1 = 1'b1;
    pts_2 = 1'b1;
    step();
    pts_1 = 1'b0;
    pts_2 = 1'b0;
    step();
    check("tie_s1", score_1, 8'h02);
    check("tie_s2", score_2, 8'h00);
    ticks(120);
    check("tie_play", gra_still, 0);

    // Player 2 scores to 12 through the BCD carry.
    for (int k = 1; k <= 12; k++) begin
      pts_2 = 1'b1;
      step();
      pts_2 = 1'b0;
      step();
      exp_bcd = 8'(((k / 10) << 4) | (k % 10));
      check($sformatf("p2_score%0d", k), score_2, exp_bcd);
      if (k < 12) begin
        check($sformatf("p2_over%0d", k), game_over, 0);
        ticks(120);
        check($sformatf("p2_play%0d", k), gra_still, 0);
      end
    end
    check("win_over", game_over, 1);
    check("win_who", winner, 2'b10);
    check("win_still", gra_still, 1);
    check("win_s1", score_1, 8'h02);

    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
    check("btn_over", game_over, 1);
    ticks(119);
    check("over_hold119", game_over, 1);
    ticks(1);
    check("over_done", game_over, 0);
    check("ng_winner", winner, 2'b10);
    check("ng_s1", score_1, 8'h02);
    check("ng_s2", score_2, 8'h12);
    check("ng_still", gra_still, 1);

    // New game clears scores and winner.
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
    check("ng2_s1", score_1, 8'h00);
    check("ng2_s2", score_2, 8'h00);
    check("ng2_win", winner, 2'b00);
    check("ng2_still", gra_still, 0);

    // Reset in the middle of a new-ball hold.
    pts_1 = 1'b1;
    step();
    pts_1 = 1'b0;
    step();
    check("mid_s1", score_1, 8'h01);
    ticks(60);
    check("mid_hold", gra_still, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_still", gra_still, 1);
    check("arst_s1", score_1, 8'h00);
    check("arst_over", game_over, 0);
    check("arst_win", winner, 2'b00);
    step();
    reset = 1'b0;
    step();

    pts_1 = 1'b1;
    step();
    pts_1 = 1'b0;
    step();
    check("ng_pts_ignored", score_1, 8'h00);
    check("ng_pts_still", gra_still, 1);
`ifdef PONG_CTRL_AUTOSTART_EN
    exp_auto = 1'b0;
`else
    exp_auto = 1'b1;
`endif
    ticks(120);
    check("auto_still", gra_still, exp_auto);

    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    step();
    check("restart_still", gra_still, 0);
    check("restart_s1", score_1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
